// File: rtl/pipe_prefix_adder.sv
// Pipelined Brent-Kung add/subtract unit with valid/ready flow control.
// Prefix levels are spread over STAGES register banks; banks collapse bubbles.
module pipe_prefix_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int N = $clog2(WIDTH);
  localparam int L = 2*N - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             c0;
  } st_t;

  // Levels 0..N-1 are the up-sweep, N..2N-2 the down-sweep.
  function automatic int lvl_dist(input int lvl);
    return (lvl < N) ? (1 << lvl) : (1 << (2*N - 2 - lvl));
  endfunction

  function automatic logic [WIDTH-1:0] lvl_mask(input int lvl);
    logic [WIDTH-1:0] m;
    int s;
    m = '0;
    s = lvl_dist(lvl);
    for (int i = 0; i < WIDTH; i++) begin
      if (lvl < N) begin
        if (((i + 1) % (2*s)) == 0)
          m[i] = 1'b1;
      end else begin
        if ((i + 1 - s) >= 2*s && ((i + 1 - s) % (2*s)) == 0)
          m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  st_t               w_pre;
  st_t               w_nx  [STAGES];
  st_t               r_st  [STAGES];
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_vin;

  // Carry-in is folded into bit 0 generate so prefix G[i] is the carry out of bit i.
  always_comb begin
    w_pre.a  = a;
    w_pre.bp = sub ? ~b : b;
    w_pre.c0 = sub | cin;
    w_pre.p  = a ^ w_pre.bp;
    w_pre.g  = (a & w_pre.bp)
             | {{(WIDTH-1){1'b0}}, w_pre.p[0] & w_pre.c0};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * L) / STAGES;
    localparam int HI = ((k + 1) * L) / STAGES;
    st_t w_src;
    if (k == 0) begin : g_first
      assign w_src = w_pre;
    end else begin : g_mid
      assign w_src = r_st[k-1];
    end
    always_comb begin
      st_t t;
      logic [WIDTH-1:0] m;
      int s;
      t = w_src;
      for (int j = LO; j < HI; j++) begin
        m   = lvl_mask(j);
        s   = lvl_dist(j);
        t.g = t.g | (m & t.p & (t.g << s));
        t.p = t.p & (~m | (t.p << s));
      end
      w_nx[k] = t;
    end
    assign w_en[k] = out_ready | ~(&r_v[STAGES-1:k]);
  end

  if (STAGES == 1) begin : g_vin1
    assign w_vin = in_valid;
  end else begin : g_vinn
    assign w_vin = {r_v[STAGES-2:0], in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++)
        r_st[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_v[k] <= w_vin[k];
          if (w_vin[k])
            r_st[k] <= w_nx[k];
        end
      end
    end
  end

  st_t              w_last;
  logic [WIDTH-1:0] w_c;

  assign w_last    = r_st[STAGES-1];
  assign w_c       = {w_last.g[WIDTH-2:0], w_last.c0};
  assign sum       = w_last.a ^ w_last.bp ^ w_c;
  assign co        = w_last.g[WIDTH-1];
  assign ovf       = (w_last.a[WIDTH-1] == w_last.bp[WIDTH-1])
                   && (sum[WIDTH-1] != w_last.a[WIDTH-1]);
  assign out_valid = r_v[STAGES-1];
  assign in_ready  = rst_n & w_en[0];

endmodule

// File: doc/pipe_prefix_adder.md
PIPE_PREFIX_ADDER -- requirements
Module: pipe_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width; power of two, 4..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline register stages, 1..log2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat presented.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  mode: 0 = a+b+cin, 1 = a-b.
REQ-011 SHALL have port out_valid  output  1  result beat presented.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port co  output  1  carry-out of bit WIDTH-1.
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL compute carries with a Brent-Kung parallel-prefix network (generate/propagate, 2*log2(WIDTH)-1 prefix levels); no ripple chain longer than one prefix level.
REQ-017 SHALL, for sub=1, use b' = ~b and carry-in 1; for sub=0, b' = b and carry-in cin.
REQ-018 SHALL give {co,sum} = a + b' + carry-in, full WIDTH+1-bit result, no truncation of co.
REQ-019 SHALL set ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
REQ-020 SHALL transfer an input beat on in_valid && in_ready, an output beat on out_valid && out_ready.
REQ-021 SHALL split prefix levels into STAGES register stages as evenly as possible; each stage carries a valid bit plus its partial state (sum bits, g/p, operands).
REQ-022 SHALL give latency of exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-023 SHALL advance stage k when stage k+1 is empty or advancing in the same cycle (bubble-collapsing); final stage advances on out_ready or when empty.
REQ-024 SHALL drive in_ready combinationally = first stage empty or advancing; throughput one beat/cycle when out_ready held high.
REQ-025 SHALL hold sum, co, ovf, out_valid stable while out_valid && !out_ready.
REQ-026 SHALL never drop, duplicate or reorder beats; beats exit in acceptance order.
REQ-027 SHALL, with in_valid=0, insert bubbles without side effects; sum/co/ovf are don't-care when out_valid=0.
REQ-028 SHALL accept a new beat in the same cycle a full pipeline drains one beat (simultaneous in/out transfer).
REQ-029 SHALL allow per-beat mode change; sub/cin travel with their beat.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear all stage valid bits; out_valid=0, sum=0, co=0, ovf=0.
REQ-031 SHALL drive in_ready=0 while rst_n low; in_ready=1 on the first cycle after release.
REQ-032 SHALL discard all in-flight beats on reset mid-operation; no beat accepted before reset emerges afterwards.

Verification (WIDTH=16, STAGES=2)
REQ-033 SHALL check: a=6500, b=25000, cin=0, sub=0 -> sum=31500, co=0, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL check: a=0x7FFF, b=0x7FFF -> sum=0xFFFE, co=0, ovf=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, co=1, ovf=0.
REQ-035 SHALL check: a=25, b=6500, sub=1, cin=1 -> sum=0xE6B5, co=0, ovf=0 (cin ignored); a=55000, b=25, sub=1 -> sum=54975, co=1.
REQ-036 SHALL check: back-to-back 8 beats with out_ready low cycles 3-6 -> in_ready deasserts when pipeline full, all 8 results exact and in order, outputs stable during stall.
REQ-037 SHALL check: rst_n pulsed low mid-stream with 2 beats in flight -> out_valid=0 immediately (asynchronous), no stale beat emitted after release, next beat correct.
REQ-038 SHALL check: random sweep over WIDTH in {4,16,64}, STAGES in {1, max} against a reference model, including simultaneous in/out transfer every cycle.
